// File: rtl/pipe_seg_reg.sv
// Parametrised pipeline segment register with valid/ready flow control,
// an optional 2-entry skid buffer, flush (bubble insert) and a saturating
// stall counter. Sits between two datapath stages.
module pipe_seg_reg #(
  parameter int unsigned       DATA_W         = 64,
  parameter bit                SKID           = 1'b1,
  parameter logic [DATA_W-1:0] RESET_DATA     = '0,
  parameter bit                CLEAR_ON_FLUSH = 1'b1,
  parameter int unsigned       CNT_W          = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              in_fire, out_fire;

  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Upstream ready: registered-only with the skid buffer, pass-through without it.
  always_comb begin
    if (SKID) begin
      in_ready = resetn & (state_q != StFull);
    end else begin
      in_ready = resetn & ((state_q == StEmpty) | out_ready);
    end
  end

  // Next-state and data-register steering; flush overrides any transfer.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
      if (CLEAR_ON_FLUSH) begin
        main_d = RESET_DATA;
        skid_d = RESET_DATA;
      end
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d = StOne;
            main_d  = in_data;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            // Only reachable with the skid buffer: without it in_fire implies out_fire here.
            state_d = StFull;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (out_fire) begin
            state_d = StOne;
            main_d  = skid_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // Saturating count of cycles where the head entry is blocked downstream.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StEmpty;
      main_q  <= RESET_DATA;
      skid_q  <= RESET_DATA;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_seg_reg.sv
// Scoreboard bench for pipe_seg_reg: one instance with the skid buffer and one
// without, both fed the same stimulus and each checked against a FIFO model.
module tb_pipe_seg_reg;

  localparam int unsigned DW     = 16;
  localparam int unsigned CW     = 4;
  localparam logic [DW-1:0] RST_D = 16'hC0DE;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          resetn;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;

  int n_vec;
  int n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam bit SK = (k == 0);
    localparam int unsigned CAP = SK ? 2 : 1;

    logic          rdy;
    logic          ov;
    logic [DW-1:0] od;
    logic [1:0]    occ;
    logic [CW-1:0] sc;

    logic [DW-1:0] q[$];
    logic [DW-1:0] last_out;
    int unsigned   stall_m;
    bit            armed;
    bit            rst_s, flush_s, fire_in_s, stall_s;
    logic [DW-1:0] din_s;

    pipe_seg_reg #(
      .DATA_W        (DW),
      .SKID          (SK),
      .RESET_DATA    (RST_D),
      .CLEAR_ON_FLUSH(1'b1),
      .CNT_W         (CW)
    ) u_dut (
      .clk      (clk),
      .resetn   (resetn),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (rdy),
      .in_data  (in_data),
      .out_valid(ov),
      .out_ready(out_ready),
      .out_data (od),
      .occupancy(occ),
      .stall_cnt(sc)
    );

    // Monitor: compare outputs mid-cycle, then record what the next edge will do.
    always @(negedge clk) begin
      bit exp_rdy;
      exp_rdy = resetn && (SK ? (q.size() < CAP) : (q.size() == 0 || out_ready));
      if (!resetn || armed) check("in_ready", k, 32'(rdy), 32'(exp_rdy));
      if (armed) begin
        check("out_valid", k, 32'(ov), 32'(q.size() > 0));
        check("occupancy", k, 32'(occ), 32'(q.size()));
        if (q.size() > 0) check("out_data", k, 32'(od), 32'(q[0]));
        else              check("out_data_hold", k, 32'(od), 32'(last_out));
        check("stall_cnt", k, 32'(sc), 32'(stall_m));
      end
      rst_s     = !resetn;
      flush_s   = flush;
      din_s     = in_data;
      fire_in_s = resetn && in_valid && exp_rdy;
      stall_s   = resetn && (q.size() > 0) && !out_ready;
      if (armed && resetn && (q.size() > 0) && out_ready) last_out = q.pop_front();
    end

    // Reference model update at the clock edge.
    always @(posedge clk) begin
      if (rst_s) begin
        q.delete();
        last_out = RST_D;
        stall_m  = 0;
        armed    = 1'b1;
      end else begin
        if (stall_s && stall_m < CNT_MAX) stall_m++;
        if (flush_s) begin
          q.delete();
          last_out = RST_D;
        end else if (fire_in_s) begin
          q.push_back(din_s);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick(1);
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    resetn    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h00AA;
    out_ready = 1'b0;
    tick(2);
    resetn   = 1'b1;
    in_valid = 1'b0;
    tick(2);

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(DW'(i));
    in_valid = 1'b0;
    tick(3);

    // Backpressure fills the skid buffer, then drains in order.
    out_ready = 1'b0;
    send(16'h0010);
    send(16'h0011);
    send(16'h0012);
    tick(2);
    out_ready = 1'b1;
    tick(3);
    in_valid = 1'b0;
    tick(3);

    // Flush with a same-cycle input that must be dropped.
    out_ready = 1'b0;
    send(16'h0020);
    send(16'h0021);
    flush = 1'b1;
    send(16'h0022);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick(3);

    // Simultaneous in/out fire from one held entry.
    out_ready = 1'b0;
    send(16'h0030);
    in_valid = 1'b0;
    tick(1);
    out_ready = 1'b1;
    send(16'h0031);
    in_valid = 1'b0;
    tick(2);

    // Stall counter saturation, then reset clears it.
    out_ready = 1'b0;
    send(16'h0040);
    in_valid = 1'b0;
    tick(20);
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    tick(2);

    // Randomised traffic with occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = DW'($urandom);
      out_ready = (c % 400 < 200) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      flush     = ($urandom_range(31) == 0);
      resetn    = ($urandom_range(199) != 0);
      tick(1);
    end
    resetn   = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
